calc_job_arbiter: RTL and testbench

CALC_JOB_ARBITER -- requirements
Module: calc_job_arbiter

---
 rtl/calc_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/calc_job_arbiter.sv | 173 +++++++++++++++++
 tb/tb_calc_job_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator job arbiter: op codes, digit limit,
// sequencer state encoding and the job legality check.
package calc_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_NUM_A = 3'd2,
        ST_OP    = 3'd3,
        ST_NUM_B = 3'd4,
        ST_EQ    = 3'd5,
        ST_WAIT  = 3'd6,
        ST_RESP  = 3'd7
    } calc_state_e;

    // Divide by zero is rejected here so the calculator never sees it.
    function automatic logic job_legal(input logic [3:0] a,
                                       input logic [2:0] op,
                                       input logic [3:0] b);
        logic op_ok;
        op_ok = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
        return op_ok && (a <= DIGIT_MAX) && (b <= DIGIT_MAX) &&
               !((op == OP_DIV) && (b == 4'd0));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer that moves only when
// the granted request is actually accepted.
module rr_arb2 (
    input  logic clk,
    input  logic clear_n,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    logic last_q;
    logic last_d;

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/calc_job_arbiter.sv
// Serves calculator jobs from two requesters one at a time: arbitrates,
// validates, drives the button sequence and holds the response until taken.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request; ready raised for the winner only
// CLR      | calc_clear pulse
// NUM_A    | first digit on calc_num
// OP       | latched op on calc_op
// NUM_B    | second digit on calc_num
// EQ       | calc_equal pulse
// WAIT     | RESULT_WAIT cycles for the calculator to settle
// RESP     | response valid, held until rsp_ready
module calc_job_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned RESULT_WAIT = 2
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_a,
    input  logic [2:0]  req0_op,
    input  logic [3:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_a,
    input  logic [2:0]  req1_op,
    input  logic [3:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        calc_clear,
    output logic [3:0]  calc_num,
    output logic [2:0]  calc_op,
    output logic        calc_equal,
    input  logic [15:0] calc_result,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(RESULT_WAIT - 1);

    calc_state_e state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  b_q, b_d;
    logic        id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_err_q, rsp_err_d;

    logic        gnt0;
    logic        gnt1;
    logic        idle;
    logic        accept;
    logic [3:0]  sel_a;
    logic [2:0]  sel_op;
    logic [3:0]  sel_b;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && ((gnt0 && req0_valid) || (gnt1 && req1_valid));
    assign sel_a  = gnt1 ? req1_a  : req0_a;
    assign sel_op = gnt1 ? req1_op : req0_op;
    assign sel_b  = gnt1 ? req1_b  : req0_b;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .clear_n (clear_n),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .accept  (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        op_d         = op_q;
        b_d          = b_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d          = sel_a;
                    op_d         = sel_op;
                    b_d          = sel_b;
                    id_d         = gnt1;
                    rsp_result_d = 16'd0;
                    if (job_legal(sel_a, sel_op, sel_b)) begin
                        rsp_err_d = 1'b0;
                        state_d   = ST_CLR;
                    end else begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_CLR:   state_d = ST_NUM_A;
            ST_NUM_A: state_d = ST_OP;
            ST_OP:    state_d = ST_NUM_B;
            ST_NUM_B: state_d = ST_EQ;
            ST_EQ: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Result is captured on the final WAIT cycle; counter stops at zero.
                if (cnt_q == 4'd0) begin
                    rsp_result_d = calc_result;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            a_q          <= 4'd0;
            op_q         <= OP_NONE;
            b_q          <= 4'd0;
            id_q         <= 1'b0;
            cnt_q        <= 4'd0;
            rsp_result_q <= 16'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            op_q         <= op_d;
            b_q          <= b_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        calc_num = 4'd0;
        if (state_q == ST_NUM_A) begin
            calc_num = a_q;
        end else if (state_q == ST_NUM_B) begin
            calc_num = b_q;
        end
    end

    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign calc_clear = (state_q == ST_CLR);
    assign calc_op    = (state_q == ST_OP) ? op_q : OP_NONE;
    assign calc_equal = (state_q == ST_EQ);
    assign busy       = !idle;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_calc_job_arbiter.sv
// Directed bench for calc_job_arbiter with a behavioural calculator and a
// response scoreboard checked by an independent monitor.
module tb_calc_job_arbiter;
    import calc_pkg::*;

    localparam int RW = 2;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_a = 4'd0, req1_a = 4'd0, req0_b = 4'd0, req1_b = 4'd0;
    logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        calc_clear, calc_equal, busy;
    logic [3:0]  calc_num;
    logic [2:0]  calc_op;
    logic [15:0] calc_result = 16'd0;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   ok;

    calc_job_arbiter #(.RESULT_WAIT(RW)) dut (
        .clk(clk), .clear_n(clear_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_op(req0_op), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_op(req1_op), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .calc_clear(calc_clear), .calc_num(calc_num), .calc_op(calc_op),
        .calc_equal(calc_equal), .calc_result(calc_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural calculator: clear, digit, op, digit, equal.
    logic [2:0]  ph = 3'd0;
    logic [3:0]  ma = 4'd0, mb = 4'd0;
    logic [2:0]  mop = 3'd0;
    always @(posedge clk) begin
        if (calc_clear) begin
            ph <= 3'd1;
        end else if (ph == 3'd1) begin
            ma <= calc_num;
            ph <= 3'd2;
        end else if (ph == 3'd2 && calc_op != 3'd0) begin
            mop <= calc_op;
            ph  <= 3'd3;
        end else if (ph == 3'd3) begin
            mb <= calc_num;
            ph <= 3'd4;
        end else if (ph == 3'd4 && calc_equal) begin
            case (mop)
                OP_ADD:  calc_result <= 16'(ma) + 16'(mb);
                OP_SUB:  calc_result <= 16'(ma) - 16'(mb);
                OP_MUL:  calc_result <= 16'(ma) * 16'(mb);
                OP_DIV:  calc_result <= (mb != 4'd0) ? 16'(ma / mb) : 16'd0;
                default: calc_result <= 16'd0;
            endcase
            ph <= 3'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [3:0] a,
                           input logic [2:0] op, input logic [3:0] b);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_op = op; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_op = op; req1_b = b;
        end
    endtask

    // Returns at posedge+1 of the acceptance edge with valid dropped.
    task automatic wait_accept(input int id, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout id=%0d actual=not_ready required=ready", id);
        end else begin
            @(posedge clk); #1;
            if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s idle_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_rsp_valid"},  32'(rsp_valid), 0);
        chk({name, "_rsp_err"},    32'(rsp_err), 0);
        chk({name, "_rsp_id"},     32'(rsp_id), 0);
        chk({name, "_rsp_result"}, 32'(rsp_result), 0);
        chk({name, "_calc_clear"}, 32'(calc_clear), 0);
        chk({name, "_calc_equal"}, 32'(calc_equal), 0);
        chk({name, "_calc_num"},   32'(calc_num), 0);
        chk({name, "_calc_op"},    32'(calc_op), 0);
        chk({name, "_busy"},       32'(busy), 0);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        clear_n = 1'b1;
    endtask

    // Monitor: pops an expected response on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp id=%0d result=%0d err=%0d required=none",
                             rsp_id, rsp_result, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id",     32'(rsp_id),     32'(e.id));
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_err",    32'(rsp_err),    32'(e.err));
                end
            end
        end
    end

    initial begin
        do_reset();

        // 5 ADD 3: button sequence and response latency.
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd5, OP_ADD, 4'd3);
        exp_q.push_back('{id: 1'b0, res: 16'd8, err: 1'b0});
        wait_accept(0, ok);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("s1_clear", 32'(calc_clear), 32'(k == 1));
            chk("s1_num",   32'(calc_num),   (k == 2) ? 5 : (k == 4) ? 3 : 0);
            chk("s1_op",    32'(calc_op),    (k == 3) ? 1 : 0);
            chk("s1_equal", 32'(calc_equal), 32'(k == 5));
            chk("s1_valid", 32'(rsp_valid),  32'(k == 8));
        end
        wait_idle("s1");

        // Simultaneous requests from reset alternate starting with req0.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd6, OP_DIV, 4'd3);
        set_req(1, 1'b1, 4'd4, OP_MUL, 4'd4);
        exp_q.push_back('{id: 1'b0, res: 16'd2, err: 1'b0});
        @(negedge clk);
        chk("s2_rdy0", 32'(req0_ready), 1);
        chk("s2_rdy1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        exp_q.push_back('{id: 1'b1, res: 16'd16, err: 1'b0});
        wait_accept(1, ok);
        wait_idle("s2a");
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd2, OP_ADD, 4'd2);
        set_req(1, 1'b1, 4'd3, OP_SUB, 4'd1);
        exp_q.push_back('{id: 1'b0, res: 16'd4, err: 1'b0});
        @(negedge clk);
        chk("s2_pair2_rdy0", 32'(req0_ready), 1);
        chk("s2_pair2_rdy1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        exp_q.push_back('{id: 1'b1, res: 16'd2, err: 1'b0});
        wait_accept(1, ok);
        wait_idle("s2b");

        // 7 DIV 0 from req1: immediate error response, calculator untouched.
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd7, OP_DIV, 4'd0);
        exp_q.push_back('{id: 1'b1, res: 16'd0, err: 1'b1});
        wait_accept(1, ok);
        @(negedge clk);
        chk("s3_valid", 32'(rsp_valid),  1);
        chk("s3_clear", 32'(calc_clear), 0);
        chk("s3_num",   32'(calc_num),   0);
        chk("s3_op",    32'(calc_op),    0);
        chk("s3_equal", 32'(calc_equal), 0);
        wait_idle("s3");

        // Out-of-range digit and undefined op.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd12, 3'b111, 4'd1);
        exp_q.push_back('{id: 1'b0, res: 16'd0, err: 1'b1});
        wait_accept(0, ok);
        wait_idle("s4");

        // 9 SUB 2 with consumer stalled; other requester must see ready low.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd9, OP_SUB, 4'd2);
        exp_q.push_back('{id: 1'b0, res: 16'd7, err: 1'b0});
        wait_accept(0, ok);
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        chk("s5_valid_seen", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd1, OP_ADD, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s5_hold_valid",  32'(rsp_valid),  1);
            chk("s5_hold_result", 32'(rsp_result), 7);
            chk("s5_hold_id",     32'(rsp_id),     0);
            chk("s5_hold_err",    32'(rsp_err),    0);
            chk("s5_rdy0",        32'(req0_ready), 0);
            chk("s5_rdy1",        32'(req1_ready), 0);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s5_idle_busy",  32'(busy),      0);
        chk("s5_idle_valid", 32'(rsp_valid), 0);

        // Reset during WAIT abandons the job.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd1, OP_ADD, 4'd1);
        wait_accept(0, ok);
        repeat (6) @(negedge clk);
        chk("s6_busy_wait", 32'(busy), 1);
        #1;
        clear_n = 1'b0;
        #1;
        check_reset_vals("s6_mid");
        @(posedge clk); #1;
        clear_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("s6_no_rsp", 32'(rsp_valid), 0);
        chk("s6_idle",   32'(busy),      0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd2, OP_MUL, 4'd3);
        set_req(1, 1'b1, 4'd8, OP_SUB, 4'd5);
        exp_q.push_back('{id: 1'b0, res: 16'd6, err: 1'b0});
        @(negedge clk);
        chk("s6_rdy0", 32'(req0_ready), 1);
        chk("s6_rdy1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        exp_q.push_back('{id: 1'b1, res: 16'd3, err: 1'b0});
        wait_accept(1, ok);
        wait_idle("s6");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
